// File: rtl/gfx_timing_ctrl.sv
// gfx_timing_ctrl
// ---------------
// Master scanline/frame sequencer for the graphics pipeline.
//
// It keeps a dot phase counter (system clocks within one pixel dot), a dot
// counter (hcount) and a line counter (vcount). It also produces the
// HBlank/VBlank/VCount-match status bits and one-clock interrupt request
// pulses for the interrupt controller.
//
// Every output is a register. Status flags are computed from the next
// counter values, so each flag changes on the same edge as the counters it
// describes.
//
// Optional feature (compile-time macro GFX_FORCED_BLANK_EN):
//   When the macro is defined, the module gains the input forced_blank
//   (DISPCNT[7]). While forced_blank is high, pixel_en is forced low and
//   hblank/vblank both read high. Counters, vcount_match and the interrupt
//   pulses do not change. With the macro undefined the port does not exist.
//
// Ports:
//   clock          in   system clock
//   reset          in   synchronous, active-high reset (wins over run)
//   run            in   counters advance only while high
//   lyc      [7:0] in   VCount compare value
//   hblank_irq_en  in   HBlank interrupt enable
//   vblank_irq_en  in   VBlank interrupt enable
//   vcount_irq_en  in   VCount interrupt enable
//   forced_blank   in   forced blank (only with GFX_FORCED_BLANK_EN)
//   hcount   [8:0] out  current dot
//   vcount   [7:0] out  current line
//   dot_phase[1:0] out  clock index within the current dot
//   pixel_en       out  strobe at phase 0 of every visible dot
//   line_start     out  pulse on the edge where hcount becomes 0
//   frame_start    out  pulse on the edge where vcount becomes 0
//   hblank         out  HBlank status flag
//   vblank         out  VBlank status flag (low again on the last line)
//   vcount_match   out  vcount == lyc
//   hblank_irq     out  HBlank interrupt request pulse
//   vblank_irq     out  VBlank interrupt request pulse
//   vcount_irq     out  VCount interrupt request pulse
module gfx_timing_ctrl #(
    parameter int CYCLES_PER_DOT = 4,
    parameter int H_VISIBLE      = 240,
    parameter int DOTS_PER_LINE  = 308,
    parameter int V_VISIBLE      = 160,
    parameter int LINES          = 228
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] lyc,
    input  logic       hblank_irq_en,
    input  logic       vblank_irq_en,
    input  logic       vcount_irq_en,
`ifdef GFX_FORCED_BLANK_EN
    input  logic       forced_blank,
`endif
    output logic [8:0] hcount,
    output logic [7:0] vcount,
    output logic [1:0] dot_phase,
    output logic       pixel_en,
    output logic       line_start,
    output logic       frame_start,
    output logic       hblank,
    output logic       vblank,
    output logic       vcount_match,
    output logic       hblank_irq,
    output logic       vblank_irq,
    output logic       vcount_irq
);

    // The counter widths are fixed, so a geometry that does not fit must
    // stop elaboration rather than wrap silently.
    if (DOTS_PER_LINE < 1 || DOTS_PER_LINE > 511) begin : g_bad_dots
        $error("gfx_timing_ctrl: DOTS_PER_LINE must be in 1..511");
    end
    if (LINES < 1 || LINES > 255) begin : g_bad_lines
        $error("gfx_timing_ctrl: LINES must be in 1..255");
    end
    if (CYCLES_PER_DOT != 1 && CYCLES_PER_DOT != 2 && CYCLES_PER_DOT != 4) begin : g_bad_cpd
        $error("gfx_timing_ctrl: CYCLES_PER_DOT must be 1, 2 or 4");
    end
    if (H_VISIBLE < 0 || H_VISIBLE >= DOTS_PER_LINE) begin : g_bad_hvis
        $error("gfx_timing_ctrl: H_VISIBLE must be below DOTS_PER_LINE");
    end
    if (V_VISIBLE < 0 || V_VISIBLE >= LINES) begin : g_bad_vvis
        $error("gfx_timing_ctrl: V_VISIBLE must be below LINES");
    end

    localparam logic [1:0] PHASE_LAST = 2'(CYCLES_PER_DOT - 1);
    localparam logic [8:0] H_LAST     = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] H_VIS      = 9'(H_VISIBLE);
    localparam logic [7:0] V_LAST     = 8'(LINES - 1);
    localparam logic [7:0] V_VIS      = 8'(V_VISIBLE);

    logic       blank;
    logic       adv_dot;
    logic       adv_line;
    logic [1:0] next_phase;
    logic [8:0] next_h;
    logic [7:0] next_v;

`ifdef GFX_FORCED_BLANK_EN
    assign blank = forced_blank;
`else
    assign blank = 1'b0;
`endif

    // Next counter position. With run low this is the current position, so
    // all flags computed from it hold by themselves.
    always_comb begin
        adv_dot    = run && (dot_phase == PHASE_LAST);
        adv_line   = adv_dot && (hcount == H_LAST);
        next_phase = dot_phase;
        next_h     = hcount;
        next_v     = vcount;
        if (run) begin
            next_phase = adv_dot ? 2'd0 : dot_phase + 2'd1;
        end
        if (adv_dot) begin
            next_h = adv_line ? 9'd0 : hcount + 9'd1;
        end
        if (adv_line) begin
            next_v = (vcount == V_LAST) ? 8'd0 : vcount + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dot_phase    <= '0;
            hcount       <= '0;
            vcount       <= '0;
            pixel_en     <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            hblank       <= 1'b0;
            vblank       <= 1'b0;
            vcount_match <= 1'b0;
            hblank_irq   <= 1'b0;
            vblank_irq   <= 1'b0;
            vcount_irq   <= 1'b0;
        end else begin
            dot_phase    <= next_phase;
            hcount       <= next_h;
            vcount       <= next_v;
            hblank       <= blank || (next_h >= H_VIS);
            vblank       <= blank || ((next_v >= V_VIS) && (next_v < V_LAST));
            pixel_en     <= !blank && run && (next_phase == 2'd0) &&
                            (next_h < H_VIS) && (next_v < V_VIS);
            // Pulses are tied to actual counter transitions, so they are
            // silent while run is low and cannot be raised by an enable or
            // by an lyc write alone.
            line_start   <= adv_line;
            frame_start  <= adv_line && (vcount == V_LAST);
            vcount_match <= (next_v == lyc);
            hblank_irq   <= hblank_irq_en && adv_dot && (next_h == H_VIS);
            vblank_irq   <= vblank_irq_en && adv_line && (next_v == V_VIS);
            vcount_irq   <= vcount_irq_en && adv_line && (next_v == lyc);
        end
    end

endmodule
